// File: rtl/tile_row_streamer_pkg.sv
// Shared types and helpers for tile_row_streamer: FSM states, default geometry,
// derived sum width and the row-count saturation rule.
package tile_row_streamer_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ROWS   = 8;
  localparam int DEF_COLS   = 16;

  // Wide enough for COLS maximal elements, so the row sum can never wrap.
  function automatic int calc_sum_w(input int data_w, input int cols);
    return data_w + $clog2(cols);
  endfunction

  // A requested count of 0, or more rows than the tile holds, means "all rows".
  function automatic int sat_rows(input int cnt, input int rows);
    return (cnt == 0 || cnt > rows) ? rows : cnt;
  endfunction

endpackage

// File: rtl/tile_row_streamer_row_sum.sv
// row_sum_tree: combinational balanced adder tree reducing one row of COLS
// unsigned elements to a SUM_W-bit sum (leaves padded to a power of two).
module row_sum_tree
  import tile_row_streamer_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int COLS   = DEF_COLS,
  localparam int SUM_W  = calc_sum_w(DATA_W, COLS)
) (
  input  logic [DATA_W-1:0] row [COLS],
  output logic [SUM_W-1:0]  sum
);

  localparam int LEAVES = 1 << $clog2(COLS);

  // Heap layout: node[0] is the root, node[LEAVES-1 +: LEAVES] are the leaves.
  logic [SUM_W-1:0] node [2*LEAVES-1];

  always_comb begin
    for (int i = 0; i < 2*LEAVES-1; i++) node[i] = '0;
    for (int i = 0; i < COLS; i++) node[LEAVES-1+i] = SUM_W'(row[i]);
    for (int i = LEAVES-2; i >= 0; i--) node[i] = node[2*i+1] + node[2*i+2];
    sum = node[0];
  end

endmodule

// File: rtl/tile_row_streamer.sv
// tile_row_streamer: accepts a ROWS x COLS tile in one handshake, then streams it
// one registered row per handshake. Row sums are built only with TILE_ROW_STREAMER_SUM_EN.
module tile_row_streamer
  import tile_row_streamer_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int ROWS   = DEF_ROWS,
  parameter  int COLS   = DEF_COLS,
  localparam int CNT_W  = $clog2(ROWS+1),
  localparam int SUM_W  = calc_sum_w(DATA_W, COLS)
) (
  input  logic              clk,
  input  logic              rst,
  // Handshakes on both sides: a transfer happens on a rising edge where
  // valid && ready; valid never depends on ready, and outputs are registered.
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_tile [ROWS][COLS],
  input  logic [CNT_W-1:0]  in_row_cnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_row [COLS],
  output logic [CNT_W-1:0]  out_row_idx,
  output logic [SUM_W-1:0]  out_row_sum,
  output logic              out_last,
  output logic              busy,
  output state_e            dbg_state
);

  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tile_q [ROWS][COLS];
  logic [CNT_W-1:0]  rows_total_q, rows_total_d;
  logic              accept, row_hs, load_row;
  logic [CNT_W-1:0]  nxt_idx;
  logic [DATA_W-1:0] nxt_row [COLS];
  logic [SUM_W-1:0]  nxt_sum;
  logic              nxt_last;

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    row_hs       = 1'b0;
    load_row     = 1'b0;
    rows_total_d = rows_total_q;
    nxt_idx      = out_row_idx;
    nxt_row      = out_row;
    case (state_q)
      IDLE: begin
        accept = in_valid;
        if (accept) begin
          state_d      = STREAM;
          rows_total_d = CNT_W'(sat_rows(int'(in_row_cnt), ROWS));
          nxt_idx      = '0;
          nxt_row      = in_tile[0];
          load_row     = 1'b1;
        end
      end
      STREAM: begin
        row_hs = out_ready;
        if (row_hs) begin
          if (out_last) begin
            state_d = IDLE;
          end else begin
            nxt_idx  = out_row_idx + CNT_W'(1);
            nxt_row  = tile_q[IDX_W'(nxt_idx)];
            load_row = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    nxt_last = (nxt_idx == rows_total_d - CNT_W'(1));
  end

`ifdef TILE_ROW_STREAMER_SUM_EN
  row_sum_tree #(
    .DATA_W (DATA_W),
    .COLS   (COLS)
  ) u_row_sum (
    .row (nxt_row),
    .sum (nxt_sum)
  );
`else
  assign nxt_sum = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rows_total_q <= '0;
      out_row      <= '{default: '0};
      out_row_idx  <= '0;
      out_row_sum  <= '0;
      out_last     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rows_total_q <= rows_total_d;
      if (load_row) begin
        out_row     <= nxt_row;
        out_row_idx <= nxt_idx;
        out_row_sum <= nxt_sum;
        out_last    <= nxt_last;
      end else if (row_hs) begin
        // Final row taken: data fields keep their last values, only last drops.
        out_last <= 1'b0;
      end
    end
  end

  // The tile store carries no reset; it is only observed after a fresh accept.
  always_ff @(posedge clk) begin
    if (!rst && accept) tile_q <= in_tile;
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == STREAM);
  assign busy      = (state_q == STREAM);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tile_row_streamer.sv
// Self-checking bench for tile_row_streamer: a row-list model fed at each tile
// accept, checked every cycle, plus hand-computed literal expectations.
module tb_tile_row_streamer;
  import tile_row_streamer_pkg::*;

  localparam int DATA_W   = 8;
  localparam int ROWS     = 8;
  localparam int COLS     = 16;
  localparam int CNT_W    = $clog2(ROWS+1);
  localparam int SUM_W    = DATA_W + $clog2(COLS);
  localparam int ROW_BITS = COLS * DATA_W;
  localparam int EXP_W    = ROW_BITS + CNT_W + SUM_W + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_tile [ROWS][COLS];
  logic [CNT_W-1:0]  in_row_cnt = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_row [COLS];
  logic [CNT_W-1:0]  out_row_idx;
  logic [SUM_W-1:0]  out_row_sum;
  logic              out_last;
  logic              busy;
  state_e            dbg_state;

  tile_row_streamer #(
    .DATA_W (DATA_W),
    .ROWS   (ROWS),
    .COLS   (COLS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_tile     (in_tile),
    .in_row_cnt  (in_row_cnt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_row_idx (out_row_idx),
    .out_row_sum (out_row_sum),
    .out_last    (out_last),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int last_final_edge = -1;
  int acc_edge = -1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [ROW_BITS-1:0] pack_row(input logic [DATA_W-1:0] r [COLS]);
    logic [ROW_BITS-1:0] b;
    b = '0;
    for (int c = 0; c < COLS; c++) b[(COLS-1-c)*DATA_W +: DATA_W] = r[c];
    return b;
  endfunction

  // Model: the accepted tile becomes the list of rows the consumer must see.
  task automatic push_model(input int cnt);
    int rows;
    int s;
    rows = (cnt == 0 || cnt > ROWS) ? ROWS : cnt;
    for (int r = 0; r < rows; r++) begin
      s = 0;
      for (int c = 0; c < COLS; c++) s += int'(in_tile[r][c]);
`ifndef TILE_ROW_STREAMER_SUM_EN
      s = 0;
`endif
      exp_q.push_back({pack_row(in_tile[r]), CNT_W'(r), SUM_W'(s), (r == rows-1)});
    end
  endtask

  // Compare process: every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      logic exp_valid;
      exp_valid = (exp_q.size() > 0);
      check("out_valid", out_valid, exp_valid);
      check("busy", busy, exp_valid);
      check("in_ready", in_ready, !exp_valid);
      check("dbg_state", dbg_state == STREAM, exp_valid);
      if (out_valid && exp_valid) begin
        check("row_fields", {pack_row(out_row), out_row_idx, out_row_sum, out_last}, exp_q[0]);
        if (out_ready) begin
          if (exp_q[0][0]) last_final_edge = cyc + 1;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_tile(input int pattern);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        case (pattern)
          0:       in_tile[r][c] = DATA_W'(r*COLS + c);
          1:       in_tile[r][c] = 8'hFF;
          2:       in_tile[r][c] = DATA_W'(r*37 + c*11 + 5);
          default: in_tile[r][c] = DATA_W'($urandom_range(0, 255));
        endcase
  endtask

  // Called in the drive phase (just after a rising edge); returns likewise.
  task automatic send_tile(input int pattern, input int cnt, input bit hold_valid);
    bit got;
    got = 1'b0;
    fill_tile(pattern);
    in_row_cnt = CNT_W'(cnt);
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    acc_edge = cyc + 1;
    @(posedge clk);
    push_model(cnt);
    #1;
    if (!hold_valid) in_valid = 1'b0;
  endtask

  task automatic advance(input int k);
    out_ready = 1'b1;
    repeat (k) @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  logic [ROW_BITS-1:0] snap_row;
  logic [SUM_W-1:0]    snap_sum;

  initial begin
    fill_tile(0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_idx", out_row_idx, 0);
    check("rst_sum", out_row_sum, 0);
    check("rst_last", out_last, 0);
    check("rst_row", pack_row(out_row), 0);
    @(posedge clk);
    #1;

    // 1: full tile, pin row 1 by hand
    send_tile(0, 0, 0);
    advance(1);
    @(negedge clk);
    check("t1_idx", out_row_idx, 1);
    check("t1_elem5", out_row[5], 21);
    check("t1_last", out_last, 0);
`ifdef TILE_ROW_STREAMER_SUM_EN
    check("t1_sum", out_row_sum, 376);
`else
    check("t1_sum", out_row_sum, 0);
`endif
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();

    // 2: row count 3, then saturated count 9
    send_tile(2, 3, 0);
    wait_idle();
    send_tile(2, 9, 0);
    wait_idle();

    // 3: backpressure on row 2, and an in_valid pulse during the stream
    out_ready = 1'b0;
    send_tile(2, 0, 0);
    advance(2);
    @(negedge clk);
    snap_row = pack_row(out_row);
    snap_sum = out_row_sum;
    check("t3_idx", out_row_idx, 2);
    @(posedge clk);
    #1;
    fill_tile(1);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_in_ready", in_ready, 0);
      check("t3_hold_idx", out_row_idx, 2);
      check("t3_hold_row", pack_row(out_row), snap_row);
      check("t3_hold_sum", out_row_sum, snap_sum);
      check("t3_hold_last", out_last, 0);
      @(posedge clk);
      #1;
      if (i == 1) in_valid = 1'b0;
    end
    out_ready = 1'b1;
    wait_idle();

    // 4: saturated elements
    out_ready = 1'b0;
    send_tile(1, 0, 0);
    @(negedge clk);
    check("t4_idx", out_row_idx, 0);
`ifdef TILE_ROW_STREAMER_SUM_EN
    check("t4_sum", out_row_sum, 4080);
`else
    check("t4_sum", out_row_sum, 0);
`endif
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();

    // 5: reset while row 4 is held
    out_ready = 1'b0;
    send_tile(3, 0, 0);
    advance(4);
    @(negedge clk);
    check("t5_idx_before", out_row_idx, 4);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("t5_in_ready_rst", in_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t5_out_valid", out_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_idx", out_row_idx, 0);
    check("t5_sum", out_row_sum, 0);
    check("t5_last", out_last, 0);
    check("t5_row", pack_row(out_row), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    send_tile(2, 2, 0);
    wait_idle();

    // 6: back-to-back tiles with in_valid held
    out_ready = 1'b1;
    send_tile(0, 3, 1);
    send_tile(2, 2, 0);
    check("t6_accept_gap", acc_edge - last_final_edge, 1);
    @(negedge clk);
    check("t6_row0_valid", out_valid, 1);
    check("t6_row0_idx", out_row_idx, 0);
    @(posedge clk);
    #1;
    wait_idle();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
